// File: rtl/power_switch_ack_model.sv
// Behavioural model of per-domain power switches: each domain ramps its ack
// a fixed number of cycles after a stable request and flags isolation misuse.
module power_switch_ack_model #(
    parameter int unsigned NUM_DOMAINS = 4,
    parameter int unsigned ACK_LATENCY = 15,
    parameter int unsigned RESET_ON    = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NUM_DOMAINS-1:0] switch_i,
    input  logic [NUM_DOMAINS-1:0] iso_i,
    input  logic                   clear_i,
    output logic [NUM_DOMAINS-1:0] ack_o,
    output logic [NUM_DOMAINS-1:0] busy_o,
    output logic [NUM_DOMAINS-1:0] violation_o
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic RESET_ACK = 1'(RESET_ON != 0);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_RAMP_UP,
        ST_ON,
        ST_RAMP_DOWN
    } state_e;

    localparam state_e RESET_STATE = RESET_ACK ? ST_ON : ST_OFF;

    state_e                   state_q [NUM_DOMAINS];
    state_e                   state_d [NUM_DOMAINS];
    logic [CNT_W-1:0]         cnt_q   [NUM_DOMAINS];
    logic [CNT_W-1:0]         cnt_d   [NUM_DOMAINS];
    logic [NUM_DOMAINS-1:0]   ack_d;
    logic [NUM_DOMAINS-1:0]   busy_d;
    logic [NUM_DOMAINS-1:0]   viol_d;
    logic [NUM_DOMAINS-1:0]   switch_q;
    logic                     armed_q;

    // State, counters and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int d = 0; d < NUM_DOMAINS; d++) begin
                state_q[d] <= RESET_STATE;
                cnt_q[d]   <= '0;
            end
            ack_o       <= {NUM_DOMAINS{RESET_ACK}};
            busy_o      <= '0;
            violation_o <= '0;
            switch_q    <= {NUM_DOMAINS{RESET_ACK}};
            armed_q     <= 1'b0;
        end else begin
            for (int d = 0; d < NUM_DOMAINS; d++) begin
                state_q[d] <= state_d[d];
                cnt_q[d]   <= cnt_d[d];
            end
            ack_o       <= ack_d;
            busy_o      <= busy_d;
            violation_o <= viol_d;
            switch_q    <= switch_i;
            armed_q     <= 1'b1;
        end
    end

    // Per-domain next state, output decode and violation tracking.
    always_comb begin
        ack_d  = '0;
        busy_d = '0;
        viol_d = violation_o;
        for (int d = 0; d < NUM_DOMAINS; d++) begin
            state_d[d] = state_q[d];
            cnt_d[d]   = (cnt_q[d] == CNT_MAX) ? cnt_q[d] : cnt_q[d] + CNT_W'(1);
            case (state_q[d])
                ST_OFF: begin
                    cnt_d[d] = '0;
                    if (switch_i[d]) state_d[d] = ST_RAMP_UP;
                end
                ST_RAMP_UP: begin
                    if (!switch_i[d]) begin
                        state_d[d] = ST_OFF;
                        cnt_d[d]   = '0;
                    end else if (cnt_q[d] == CNT_LAST) begin
                        state_d[d] = ST_ON;
                        cnt_d[d]   = '0;
                    end
                end
                ST_ON: begin
                    cnt_d[d] = '0;
                    if (!switch_i[d]) state_d[d] = ST_RAMP_DOWN;
                end
                ST_RAMP_DOWN: begin
                    if (switch_i[d]) begin
                        state_d[d] = ST_ON;
                        cnt_d[d]   = '0;
                    end else if (cnt_q[d] == CNT_LAST) begin
                        state_d[d] = ST_OFF;
                        cnt_d[d]   = '0;
                    end
                end
                default: begin
                    state_d[d] = RESET_STATE;
                    cnt_d[d]   = '0;
                end
            endcase
            ack_d[d]  = (state_d[d] == ST_ON) || (state_d[d] == ST_RAMP_DOWN);
            busy_d[d] = (state_d[d] == ST_RAMP_UP) || (state_d[d] == ST_RAMP_DOWN);
            // New violations take priority over a same-cycle clear.
            if (armed_q) begin
                viol_d[d] = (violation_o[d] & ~clear_i)
                          | (switch_q[d] & ~switch_i[d] & ~iso_i[d])
                          | (((state_q[d] == ST_OFF) || (state_q[d] == ST_RAMP_DOWN))
                             & ~iso_i[d]);
            end else begin
                viol_d[d] = violation_o[d] & ~clear_i;
            end
        end
    end

endmodule
